ex_stage_alu: RTL and testbench

EX_STAGE_ALU -- requirements
Module: ex_stage_alu

---
 rtl/ex_stage_alu.sv | 119 +++++++++++
 tb/tb_ex_stage_alu.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_alu.sv
// Execute stage: single-cycle AND/OR/ADD/SUB/ADDI/ADDR plus a fixed XLEN-step radix-2 shift-add MUL.
// Stalls upstream for exactly XLEN cycles per MUL; flush/reset abort any operation in flight.
module ex_stage_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [2:0]      Op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [4:0]      rsd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [4:0]      rsd_o,
  output logic            wr_en_o
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] MUL_BUSY = 1'b1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_ADDR = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  logic [0:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_next;
  logic [XLEN-1:0] alu_res;
  logic            accept;

  assign accept  = (state == IDLE) && valid_i && !flush_i;
  assign stall_o = (state == MUL_BUSY);
  assign wr_en_o = valid_o && (rsd_o != 5'd0);

  always_comb begin
    alu_res = '0;
    case (Op_i)
      OP_AND:  alu_res = rs1_data_i & rs2_data_i;
      OP_OR:   alu_res = rs1_data_i | rs2_data_i;
      OP_ADD:  alu_res = rs1_data_i + rs2_data_i;
      OP_SUB:  alu_res = rs1_data_i - rs2_data_i;
      OP_ADDI: alu_res = rs1_data_i + imm_i;
      OP_ADDR: alu_res = rs1_data_i + imm_i;
      default: alu_res = '0;
    endcase
  end

  // Only the low XLEN product bits are kept, so the accumulator never needs widening.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      valid_o    <= 1'b0;
      result_o   <= '0;
      rs2_data_o <= '0;
      rsd_o      <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid_o <= 1'b0;
          if (accept) begin
            if (Op_i == OP_MUL) begin
              state      <= MUL_BUSY;
              cnt        <= '0;
              mcand      <= rs1_data_i;
              mplier     <= rs2_data_i;
              acc        <= '0;
              rsd_o      <= rsd_i;
              rs2_data_o <= rs2_data_i;
            end else if (Op_i != OP_NOP) begin
              valid_o    <= 1'b1;
              result_o   <= alu_res;
              rs2_data_o <= rs2_data_i;
              rsd_o      <= rsd_i;
            end
          end
        end
        default: begin
          valid_o <= 1'b0;
          if (flush_i) begin
            state <= IDLE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST_STEP) begin
              state    <= IDLE;
              valid_o  <= 1'b1;
              result_o <= acc_next;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_alu.sv
// Directed bench for ex_stage_alu: single-cycle ops, MUL timing, flush/reset aborts.
module tb_ex_stage_alu;

  logic        clk;
  logic        rst_i;
  logic        valid_i;
  logic [2:0]  Op_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_i;
  logic [4:0]  rsd_i;
  logic        flush_i;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [31:0] rs2_data_o;
  logic [4:0]  rsd_o;
  logic        wr_en_o;

  int checks = 0;
  int errors = 0;

  ex_stage_alu #(.XLEN(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .Op_i       (Op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .imm_i      (imm_i),
    .rsd_i      (rsd_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .rs2_data_o (rs2_data_o),
    .rsd_o      (rsd_o),
    .wr_en_o    (wr_en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rd);
    valid_i    = v;
    Op_i       = op;
    rs1_data_i = a;
    rs2_data_i = b;
    imm_i      = imm;
    rsd_i      = rd;
  endtask

  initial begin
    int stall_cnt;
    int pulses;
    int guard;

    rst_i   = 1'b1;
    flush_i = 1'b0;
    drive(1'b0, 3'b111, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    tick();
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_wr_en", {31'b0, wr_en_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rs2", rs2_data_o, 32'd0);
    chk("rst_rsd", {27'b0, rsd_o}, 32'd0);

    // ADD accepted on the first edge out of reset, with signed-overflow wrap
    rst_i = 1'b0;
    drive(1'b1, 3'b010, 32'h7FFF_FFFF, 32'h1, 32'h0, 5'd5);
    tick();
    chk("add_valid", {31'b0, valid_o}, 32'd1);
    chk("add_result", result_o, 32'h8000_0000);
    chk("add_wr_en", {31'b0, wr_en_o}, 32'd1);
    chk("add_rsd", {27'b0, rsd_o}, 32'd5);

    drive(1'b1, 3'b011, 32'h0, 32'h1, 32'h0, 5'd1);
    tick();
    chk("sub_result", result_o, 32'hFFFF_FFFF);

    drive(1'b1, 3'b110, 32'h100, 32'hDEAD, 32'hFFFF_FFFC, 5'd2);
    tick();
    chk("addr_result", result_o, 32'h0000_00FC);
    chk("addr_rs2", rs2_data_o, 32'h0000_DEAD);

    drive(1'b1, 3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 5'd4);
    tick();
    chk("and_result", result_o, 32'h0000_F000);

    drive(1'b1, 3'b101, 32'h10, 32'h0, 32'hFFFF_FFFF, 5'd6);
    tick();
    chk("addi_result", result_o, 32'h0000_000F);

    drive(1'b1, 3'b001, 32'h0000_00F0, 32'h0000_000F, 32'h0, 5'd0);
    tick();
    chk("or_valid", {31'b0, valid_o}, 32'd1);
    chk("or_result", result_o, 32'h0000_00FF);
    chk("or_wr_en_rd0", {31'b0, wr_en_o}, 32'd0);

    drive(1'b1, 3'b111, 32'h1234, 32'h5678, 32'h0, 5'd7);
    tick();
    chk("nop_valid", {31'b0, valid_o}, 32'd0);
    chk("nop_result_hold", result_o, 32'h0000_00FF);

    drive(1'b0, 3'b010, 32'h1, 32'h1, 32'h0, 5'd7);
    tick();
    chk("idle_valid", {31'b0, valid_o}, 32'd0);

    // Flush wins over acceptance in IDLE
    drive(1'b1, 3'b010, 32'h1, 32'h1, 32'h0, 5'd7);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_idle_valid", {31'b0, valid_o}, 32'd0);
    chk("flush_idle_result", result_o, 32'h0000_00FF);

    // MUL 0x00010001^2, upstream holds the instruction while stalled
    drive(1'b1, 3'b100, 32'h0001_0001, 32'h0001_0001, 32'h0, 5'd3);
    tick();
    chk("mul1_accept_valid", {31'b0, valid_o}, 32'd0);
    stall_cnt = 0;
    guard = 0;
    while (!valid_o && guard < 40) begin
      if (stall_o) stall_cnt++;
      tick();
      guard++;
    end
    chk("mul1_stall_cycles", stall_cnt, 32'd32);
    chk("mul1_valid", {31'b0, valid_o}, 32'd1);
    chk("mul1_result", result_o, 32'h0002_0001);
    chk("mul1_stall_at_pulse", {31'b0, stall_o}, 32'd0);
    chk("mul1_rsd", {27'b0, rsd_o}, 32'd3);
    chk("mul1_wr_en", {31'b0, wr_en_o}, 32'd1);
    drive(1'b0, 3'b111, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    chk("mul1_single_pulse", {31'b0, valid_o}, 32'd0);

    // MUL 0xFFFFFFFF^2 followed immediately by ADD 2+3
    drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 5'd8);
    tick();
    pulses = 0;
    guard = 0;
    while (!valid_o && guard < 40) begin
      tick();
      guard++;
    end
    if (valid_o) pulses++;
    chk("mul2_result", result_o, 32'h0000_0001);
    drive(1'b1, 3'b010, 32'h2, 32'h3, 32'h0, 5'd9);
    tick();
    if (valid_o) pulses++;
    chk("mul2_follow_valid", {31'b0, valid_o}, 32'd1);
    chk("mul2_follow_result", result_o, 32'h0000_0005);
    chk("mul2_follow_rsd", {27'b0, rsd_o}, 32'd9);
    drive(1'b0, 3'b111, 32'h0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid_o) pulses++;
    end
    chk("mul2_pulse_count", pulses, 32'd2);

    // Flush at busy cycle 10 aborts the multiply
    drive(1'b1, 3'b100, 32'h3, 32'h5, 32'h0, 5'd10);
    tick();
    for (int i = 0; i < 9; i++) tick();
    chk("flush_busy_stall_before", {31'b0, stall_o}, 32'd1);
    flush_i = 1'b1;
    drive(1'b0, 3'b111, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    flush_i = 1'b0;
    chk("flush_busy_stall_after", {31'b0, stall_o}, 32'd0);
    chk("flush_busy_valid", {31'b0, valid_o}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid_o) pulses++;
    end
    chk("flush_busy_no_product", pulses, 32'd0);

    // Reset at busy cycle 10 aborts and clears every output
    drive(1'b1, 3'b100, 32'h7, 32'h9, 32'h0, 5'd11);
    tick();
    for (int i = 0; i < 9; i++) tick();
    rst_i = 1'b1;
    drive(1'b0, 3'b111, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    rst_i = 1'b0;
    chk("rst_busy_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_busy_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_busy_wr_en", {31'b0, wr_en_o}, 32'd0);
    chk("rst_busy_result", result_o, 32'd0);
    chk("rst_busy_rs2", rs2_data_o, 32'd0);
    chk("rst_busy_rsd", {27'b0, rsd_o}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid_o) pulses++;
    end
    chk("rst_busy_no_product", pulses, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
